// File: rtl/interboard_tx_fsm_pkg.sv
// Shared inter-board link definitions.
// Holds the 24-bit frame geometry (frame width, chunk width, chunk count), the
// width and bit offset of every game-message field inside the frame, the
// transmit FSM state encoding and small helpers that pack a message into a
// frame and pick a chunk out of it. The receive stage imports the same
// constants, so both ends of the link agree on the layout.
package interboard_tx_fsm_pkg;

  localparam int FRAME_W = 24;
  localparam int CHUNK_W = 6;
  localparam int CHUNKS  = 4;

  // Field widths.
  localparam int MOVE_DIR_W = 1;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int MSG_TYPE_W = 4;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;

  // Field LSB positions; frame[23:22] is always zero.
  localparam int SEL_LEN_LSB  = 0;
  localparam int CARD_LSB     = SEL_LEN_LSB + SEL_LEN_W;    // 3
  localparam int MSG_TYPE_LSB = CARD_LSB + CARD_W;          // 9
  localparam int BLOCK_Y_LSB  = MSG_TYPE_LSB + MSG_TYPE_W;  // 13
  localparam int BLOCK_X_LSB  = BLOCK_Y_LSB + BLOCK_Y_W;    // 16
  localparam int MOVE_DIR_LSB = BLOCK_X_LSB + BLOCK_X_W;    // 21

  typedef logic [FRAME_W-1:0]         frame_t;
  typedef logic [CHUNK_W-1:0]         chunk_t;
  typedef logic [$clog2(CHUNKS)-1:0]  chunk_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO,
    DONE,
    ABORT
  } tx_state_e;

  function automatic frame_t pack_frame(
    input logic                  move_dir,
    input logic [BLOCK_X_W-1:0]  block_x,
    input logic [BLOCK_Y_W-1:0]  block_y,
    input logic [MSG_TYPE_W-1:0] msg_type,
    input logic [CARD_W-1:0]     card,
    input logic [SEL_LEN_W-1:0]  sel_len
  );
    frame_t f;
    f = '0;
    f[MOVE_DIR_LSB +: MOVE_DIR_W] = move_dir;
    f[BLOCK_X_LSB  +: BLOCK_X_W]  = block_x;
    f[BLOCK_Y_LSB  +: BLOCK_Y_W]  = block_y;
    f[MSG_TYPE_LSB +: MSG_TYPE_W] = msg_type;
    f[CARD_LSB     +: CARD_W]     = card;
    f[SEL_LEN_LSB  +: SEL_LEN_W]  = sel_len;
    return f;
  endfunction

  // Chunk 0 is the most-significant 6 bits of the frame.
  function automatic chunk_t frame_chunk(input frame_t f, input chunk_idx_t idx);
    return f[FRAME_W-1-CHUNK_W*int'(idx) -: CHUNK_W];
  endfunction

endpackage

// File: rtl/interboard_tx_fsm_if.sv
// Controller-side command bus plus link pins of the inter-board transmitter.
//   master : game controller / pin-driver side (drives ctrl_*, ack_in)
//   slave  : transmitter (drives req_out, data_out, data_oe, status pulses)
interface interboard_tx_fsm_if;
  import interboard_tx_fsm_pkg::*;

  logic                  ctrl_en;
  logic                  ctrl_move_dir;
  logic [BLOCK_X_W-1:0]  ctrl_block_x;
  logic [BLOCK_Y_W-1:0]  ctrl_block_y;
  logic [MSG_TYPE_W-1:0] ctrl_msg_type;
  logic [CARD_W-1:0]     ctrl_card;
  logic [SEL_LEN_W-1:0]  ctrl_sel_len;
  logic                  ack_in;
  logic                  req_out;
  logic [CHUNK_W-1:0]    data_out;
  logic                  data_oe;
  logic                  busy;
  logic                  tx_done;
  logic                  tx_err;

  modport master (
    output ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
           ctrl_msg_type, ctrl_card, ctrl_sel_len, ack_in,
    input  req_out, data_out, data_oe, busy, tx_done, tx_err
  );

  modport slave (
    input  ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
           ctrl_msg_type, ctrl_card, ctrl_sel_len, ack_in,
    output req_out, data_out, data_oe, busy, tx_done, tx_err
  );

endinterface

// File: rtl/interboard_tx_fsm_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (Ack on the transmit
// side, Request on the receive side).
//   clk, rst : capture clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output, two cycles of latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: flops assigned with <= so both stages sample the pre-edge values;
  // with = the input would fall straight through both stages in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/interboard_tx_fsm.sv
// Inter-board transmit FSM.
// Latches one game message on a ctrl_en pulse, packs it into a 24-bit frame
// and sends it as four 6-bit chunks, MSB chunk first, each using a four-phase
// Request/Ack handshake. Ack is synchronized before use.
//   clk, rst       : system clock, asynchronous active-high reset
//   bus.ctrl_*     : message fields and the start pulse from the controller
//   bus.ack_in     : raw Ack pin from the peer board
//   bus.req_out    : Request pin value
//   bus.data_out   : data pin value (chunk being sent)
//   bus.data_oe    : enable for the Request/data tri-state drivers
//   bus.busy       : high from accept until back in IDLE
//   bus.tx_done    : one-cycle pulse, whole frame acknowledged
//   bus.tx_err     : one-cycle pulse, transfer aborted on an Ack timeout
module interboard_tx_fsm
  import interboard_tx_fsm_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  interboard_tx_fsm_if.slave bus
);

  // Timer covers both the setup count and the Ack timeout.
  localparam int TMR_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  typedef logic [TMR_W-1:0] tmr_t;

  localparam tmr_t       SETUP_LAST   = tmr_t'(SETUP_CYC - 1);
  localparam tmr_t       TIMEOUT_LAST = tmr_t'(TIMEOUT_CYC - 1);
  localparam chunk_idx_t LAST_CHUNK   = chunk_idx_t'(CHUNKS - 1);

  tx_state_e  state_q, state_d;
  frame_t     frame_q, frame_d;
  chunk_idx_t chunk_q, chunk_d;
  tmr_t       timer_q, timer_d;
  chunk_t     data_q,  data_d;
  logic       req_q,   req_d;
  logic       oe_q,    oe_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       err_q,   err_d;

  logic       ack_s;
  tmr_t       timer_inc;
  frame_t     new_frame;
  chunk_idx_t chunk_next;

  sync_2ff #(.W(1)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ack_in),
    .q   (ack_s)
  );

  // Saturating increment: the timer never wraps back to zero.
  assign timer_inc  = (timer_q == '1) ? timer_q : tmr_t'(timer_q + 1'b1);
  assign chunk_next = chunk_idx_t'(chunk_q + 1'b1);
  assign new_frame  = pack_frame(bus.ctrl_move_dir, bus.ctrl_block_x,
                                 bus.ctrl_block_y, bus.ctrl_msg_type,
                                 bus.ctrl_card, bus.ctrl_sel_len);

  // NOTE: every register (the frame included) is cleared by reset, so the
  // pins fall immediately when rst rises, even mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      chunk_q <= '0;
      timer_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      chunk_q <= chunk_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      req_q   <= req_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every next-state value is given a default before the case so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    chunk_d = chunk_q;
    timer_d = timer_q;
    data_d  = data_q;
    req_d   = req_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ctrl_en) begin
          frame_d = new_frame;
          chunk_d = '0;
          timer_d = '0;
          data_d  = frame_chunk(new_frame, '0);
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end

      // Data has been on the pins since entry; Request rises after the
      // setup time so the peer never samples a changing bus.
      SETUP: begin
        if (timer_q == SETUP_LAST) begin
          req_d   = 1'b1;
          timer_d = '0;
          state_d = WAIT_ACK_HI;
        end else begin
          timer_d = timer_inc;
        end
      end

      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          timer_d = '0;
          state_d = WAIT_ACK_LO;
        end else if (timer_q == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          oe_d    = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ABORT;
        end else begin
          timer_d = timer_inc;
        end
      end

      // The next chunk goes onto the pins only once Ack is low again, so
      // data never changes while either handshake line is high.
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          timer_d = '0;
          if (chunk_q == LAST_CHUNK) begin
            oe_d    = 1'b0;
            data_d  = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            chunk_d = chunk_next;
            data_d  = frame_chunk(frame_q, chunk_next);
            state_d = SETUP;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          oe_d    = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ABORT;
        end else begin
          timer_d = timer_inc;
        end
      end

      // busy stays high through the pulse cycle so a ctrl_en landing here
      // is dropped like any other request made while busy.
      DONE, ABORT: begin
        busy_d  = 1'b0;
        timer_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_out  = req_q;
  assign bus.data_out = data_q;
  assign bus.data_oe  = oe_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;

endmodule
